// File: rtl/mod_acc.sv
// mod_acc: accumulates K reduced products into one sum mod Q with valid/ready on both sides.
// Optional MOD_ACC_CHK_EN adds a sticky err flag and pre-reduction of out-of-range terms.
module mod_acc #(
    parameter int WIDTH = 13,
    parameter int Q     = 7681,
    parameter int K     = 4,
    parameter int CNT_W = $clog2(K) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef MOD_ACC_CHK_EN
    output logic             err,
`endif
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
    localparam logic [WIDTH:0] QW = (WIDTH+1)'(Q);
    state_t state, state_n;
    logic [WIDTH-1:0] acc, acc_n, dat_n, term, nxt;
    logic [CNT_W-1:0] count, count_n;
    logic [WIDTH:0] s, s_sub;
    logic take, last;
    assign in_ready  = state != HOLD;
    assign out_valid = state == HOLD;
    assign busy      = count != '0;
    assign take      = in_valid && in_ready;
    // count is 0 in IDLE, so K == 1 completes on the first term without a special case
    assign last      = count == CNT_W'(K - 1);
`ifdef MOD_ACC_CHK_EN
    logic oor;
    assign oor  = in_data >= WIDTH'(Q);
    assign term = oor ? in_data - WIDTH'(Q) : in_data;
    always_ff @(posedge clk or posedge rst)
        if (rst) err <= 1'b0;
        else if (take && oor) err <= 1'b1;
`else
    assign term = in_data;
`endif
    assign s     = {1'b0, state == ACC ? acc : WIDTH'(0)} + {1'b0, term};
    assign s_sub = s - QW;
    assign nxt   = s >= QW ? s_sub[WIDTH-1:0] : s[WIDTH-1:0];
    always_comb begin
        state_n = state;
        acc_n   = acc;
        count_n = count;
        dat_n   = out_data;
        if (state == HOLD) begin
            state_n = out_ready ? IDLE : HOLD;
        end else if (take) begin
            state_n = last ? HOLD : ACC;
            acc_n   = last ? '0 : nxt;
            count_n = last ? '0 : count + CNT_W'(1);
            dat_n   = last ? nxt : out_data;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            out_data <= '0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            count    <= count_n;
            out_data <= dat_n;
        end
endmodule

// File: tb/tb_mod_acc.sv
// tb_mod_acc: scoreboard bench for mod_acc, random and directed streams against a mod-Q sum model.
module tb_mod_acc;
    localparam int W = 13, Q = 7681, K = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
    logic [W-1:0] in_data = '0, out_data;
    logic k2_valid = 1'b0, k2_ready, k2_out_valid, k2_out_ready = 1'b1, k2_busy;
    logic [W-1:0] k2_data = '0, k2_out_data;
`ifdef MOD_ACC_CHK_EN
    logic err, k2_err;
`endif
    int checks = 0, errors = 0;
    int exp_q[$];
    int mdl_sum = 0, mdl_n = 0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    mod_acc #(.WIDTH(W), .Q(Q), .K(K)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef MOD_ACC_CHK_EN
        .err(err),
`endif
        .busy(busy));

    mod_acc #(.WIDTH(W), .Q(Q), .K(2)) u_k2 (
        .clk(clk), .rst(rst), .in_valid(k2_valid), .in_ready(k2_ready), .in_data(k2_data),
        .out_valid(k2_out_valid), .out_ready(k2_out_ready), .out_data(k2_out_data),
`ifdef MOD_ACC_CHK_EN
        .err(k2_err),
`endif
        .busy(k2_busy));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // monitor: every presented result must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0d required no output", out_data);
            end else begin
                chk("out_data", int'(out_data), exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input int v, input int gap);
        int n = 0;
        int t = v;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = W'(v);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef MOD_ACC_CHK_EN
        if (t >= Q) t -= Q;
`endif
        mdl_sum = (mdl_sum + t) % Q;
        mdl_n++;
        if (mdl_n == K) begin
            exp_q.push_back(mdl_sum);
            mdl_sum = 0;
            mdl_n = 0;
            chk("busy_done", int'(busy), 0);
        end else begin
            chk("partial", int'(u_dut.acc), mdl_sum);
            chk("busy", int'(busy), 1);
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        mdl_sum = 0;
        mdl_n = 0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        #3 rst = 1'b0;
    endtask

    initial begin
        int n;
        #23 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        // continuous stream, partial sums 4592, 3562, 1504 then 1088
        send(4592, 0); send(6651, 0); send(5623, 0); send(7265, 0);
        // K=2 held by out_ready=0
        @(negedge clk);
        k2_out_ready = 1'b0;
        k2_valid = 1'b1;
        k2_data = W'(4592);
        @(negedge clk);
        k2_data = W'(6651);
        @(negedge clk);
        k2_data = W'(100);
        repeat (5) begin
            chk("k2_hold_valid", int'(k2_out_valid), 1);
            chk("k2_hold_data", int'(k2_out_data), 3562);
            chk("k2_hold_ready", int'(k2_ready), 0);
            @(negedge clk);
        end
        k2_out_ready = 1'b1;
        @(negedge clk);
        k2_valid = 1'b0;
        chk("k2_release_valid", int'(k2_out_valid), 0);
        chk("k2_release_ready", int'(k2_ready), 1);
        chk("k2_no_third", int'(k2_busy), 0);
        // boundary values with gaps, partial sums 7680, 0, 0 then 7680
        send(7680, 1); send(1, 1); send(0, 1); send(7680, 1);
        // reset mid-sum discards the partial
        send(1234, 0); send(4321, 0);
        do_reset();
        repeat (4) send(1, 0);
`ifdef MOD_ACC_CHK_EN
        send(8000, 0);
        chk("err_set", int'(err), 1);
        send(10, 0); send(20, 0); send(30, 0);
        chk("err_sticky", int'(err), 1);
        do_reset();
        chk("err_clear", int'(err), 0);
`endif
        // random sums with random gaps and backpressure
        rand_rdy = 1'b1;
        repeat (20 * K) send(int'($urandom_range(0, Q - 1)), int'($urandom_range(0, 2)));
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
